// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared state encoding, ROM marker words and default camera ID
// for the OV7670 configuration sequencer.
package ov7670_pkg;
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, SEND, WAIT_BUSY, WAIT_DONE, DELAY, NEXT, DONE
    } state_e;
    localparam logic [15:0] ROM_END    = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY  = 16'hFFF0;
    localparam logic [7:0]  DEF_CAM_ID = 8'h42;
endpackage

// File: rtl/ov7670_config_sequencer_if.sv
// ov7670_config_sequencer_if: config ROM read port plus SCCB write-master handshake.
interface ov7670_config_sequencer_if;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_ready;
    logic        sccb_start;
    logic [7:0]  sccb_id;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    modport master (output rom_addr, sccb_start, sccb_id, sccb_reg, sccb_val,
                    input  rom_data, sccb_ready);
    modport slave  (input  rom_addr, sccb_start, sccb_id, sccb_reg, sccb_val,
                    output rom_data, sccb_ready);
endinterface

// File: rtl/ov7670_delay_counter.sv
// ov7670_delay_counter: loadable down-counter that parks at zero and flags it.
module ov7670_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the config ROM and issues SCCB register writes.
// Define OV7670_CFG_TIMEOUT_EN to add the SCCB wait timeout and the err_o port.
module ov7670_config_sequencer
    import ov7670_pkg::*;
#(
    parameter int          CLK_FREQ = 25000000,
    parameter int          DELAY_MS = 10,
    parameter logic [7:0]  CAM_ID   = DEF_CAM_ID
`ifdef OV7670_CFG_TIMEOUT_EN
  , parameter int          TIMEOUT_CYCLES = 100000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic done_o,
`ifdef OV7670_CFG_TIMEOUT_EN
    output logic err_o,
`endif
    ov7670_config_sequencer_if.master bus
);
    localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
    localparam int DW = $clog2(DELAY_CYCLES + 1);

    state_e     state_q;
    logic [7:0] addr_q, reg_q, val_q;
    logic       start_q, done_q;
    logic       dly_zero, timeout;

    ov7670_delay_counter #(.W(DW)) u_dly (
        .clk, .rst,
        .load_i(state_q == DECODE && bus.rom_data == ROM_DELAY),
        .load_val_i(DW'(DELAY_CYCLES - 1)),
        .en_i(state_q == DELAY),
        .zero_o(dly_zero)
    );

`ifdef OV7670_CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic in_xfer, to_zero, err_q;
    assign in_xfer = state_q inside {SEND, WAIT_BUSY, WAIT_DONE};
    // Held loaded outside the transfer states so each transfer gets a fresh budget.
    ov7670_delay_counter #(.W(TW)) u_to (
        .clk, .rst,
        .load_i(!in_xfer),
        .load_val_i(TW'(TIMEOUT_CYCLES - 1)),
        .en_i(in_xfer),
        .zero_o(to_zero)
    );
    assign timeout = in_xfer && to_zero;
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
        else if (start_i && state_q inside {IDLE, DONE}) err_q <= 1'b0;
    assign err_o = err_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (timeout) begin
                state_q <= DONE;
                done_q  <= 1'b1;
            end else
                case (state_q)
                    IDLE, DONE:
                        if (start_i) begin
                            addr_q  <= '0;
                            done_q  <= 1'b0;
                            state_q <= FETCH;
                        end
                    FETCH: state_q <= DECODE;
                    DECODE:
                        if (bus.rom_data == ROM_END) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (bus.rom_data == ROM_DELAY) state_q <= DELAY;
                        else begin
                            reg_q   <= bus.rom_data[15:8];
                            val_q   <= bus.rom_data[7:0];
                            state_q <= SEND;
                        end
                    SEND:
                        if (bus.sccb_ready) begin
                            start_q <= 1'b1;
                            state_q <= WAIT_BUSY;
                        end
                    WAIT_BUSY: if (!bus.sccb_ready) state_q <= WAIT_DONE;
                    WAIT_DONE: if (bus.sccb_ready) state_q <= NEXT;
                    DELAY: if (dly_zero) state_q <= NEXT;
                    NEXT:
                        if (addr_q == 8'hFF) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + 8'd1;
                            state_q <= FETCH;
                        end
                    default: state_q <= IDLE;
                endcase
        end

    assign bus.rom_addr   = addr_q;
    assign bus.sccb_start = start_q;
    assign bus.sccb_id    = CAM_ID;
    assign bus.sccb_reg   = reg_q;
    assign bus.sccb_val   = val_q;
    assign done_o         = done_q;
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: table-driven ROM images with a write scoreboard.
// Define OV7670_CFG_TIMEOUT_EN to also exercise the timeout path.
module tb_ov7670_config_sequencer;
    import ov7670_pkg::*;

    typedef struct {
        logic [3:0][15:0] w;
        logic [2:0][15:0] e;
        int               nexp;
        logic [7:0]       end_addr;
        int               lat;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, done;
`ifdef OV7670_CFG_TIMEOUT_EN
    logic err;
`endif
    ov7670_config_sequencer_if bus();

    ov7670_config_sequencer #(
        .CLK_FREQ(1000000), .DELAY_MS(1), .CAM_ID(8'h42)
`ifdef OV7670_CFG_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .done_o(done),
`ifdef OV7670_CFG_TIMEOUT_EN
        .err_o(err),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int   busy_len = 1, busy_cnt = 0, cyc = 0;
    logic hold_low = 1'b0;
    always @(posedge clk or posedge rst)
        if (rst) busy_cnt <= 0;
        else if (bus.sccb_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign bus.sccb_ready = !hold_low && busy_cnt == 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0, total = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    logic [15:0] exp_q[$];
    int   pulses = 0, first_cyc = -1;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (bus.sccb_start) begin
            pulses++;
            if (first_cyc < 0) first_cyc = cyc;
            chk("sccb_one_cycle", prev_start, 0);
            chk("sccb_id", bus.sccb_id, 8'h42);
            chk("sccb_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("sccb_write", {bus.sccb_reg, bus.sccb_val}, exp_q.pop_front());
        end
        prev_start = bus.sccb_start;
    end

    function automatic vec_t mk(logic [15:0] w0, w1, w2, w3, e0, e1, e2, int n, logic [7:0] ea, int lat);
        vec_t v;
        v.w = {w3, w2, w1, w0};
        v.e = {e2, e1, e0};
        v.nexp = n;
        v.end_addr = ea;
        v.lat = lat;
        return v;
    endfunction

    int t0;
    task automatic kick();
        pulses = 0;
        first_cyc = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
        chk("done_cleared", done, 0);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < 256; i++) rom[i] = ROM_END;
        for (int i = 0; i < 4; i++) rom[i] = v.w[i];
        for (int i = 0; i < v.nexp; i++) exp_q.push_back(v.e[i]);
        kick();
        wait_done(5000);
        repeat (3) @(negedge clk);
        chk("end_addr", bus.rom_addr, v.end_addr);
        chk("pulse_count", pulses, v.nexp);
        chk("queue_empty", exp_q.size(), 0);
        if (v.lat >= 0) chk("first_write_latency", first_cyc - t0, v.lat);
    endtask

    vec_t vecs[5];
    initial begin
        vecs[0] = mk(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1280, 0, 0, 1, 8'd1, 3);
        vecs[1] = mk(16'hFFF0, 16'h1204, 16'hFFFF, 16'hFFFF, 16'h1204, 0, 0, 1, 8'd2, 1006);
        vecs[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 8'd0, -1);
        vecs[3] = mk(16'h0102, 16'h0304, 16'h0506, 16'hFFFF, 16'h0102, 16'h0304, 16'h0506, 3, 8'd3, 3);
        vecs[4] = mk(16'h0A0B, 16'hFFF0, 16'hFFFF, 16'hFFFF, 16'h0A0B, 0, 0, 1, 8'd2, 3);
        for (int i = 0; i < 256; i++) rom[i] = ROM_END;

        repeat (3) @(negedge clk);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_sccb_start", bus.sccb_start, 0);
        chk("rst_reg_val", {bus.sccb_reg, bus.sccb_val}, 0);
        chk("rst_done", done, 0);
        chk("rst_id", bus.sccb_id, 8'h42);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Ready held low across SEND: no pulse, reg/val stable, then exactly one pulse.
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) rom[i] = ROM_END;
            rom[0] = 16'h3344;
            exp_q.push_back(16'h3344);
            hold_low = 1'b1;
            kick();
            for (int i = 1; i <= 50; i++) begin
                @(negedge clk);
                if (bus.sccb_start || (i >= 2 && {bus.sccb_reg, bus.sccb_val} != 16'h3344)) bad++;
            end
            chk("hold_no_start", bad, 0);
            hold_low = 1'b0;
            wait_done(200);
            chk("hold_pulses", pulses, 1);
            chk("hold_latency", first_cyc - t0, 51);
        end

        // No end marker: 256 writes, stop at address 255.
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'h1100;
            exp_q.push_back(16'h1100);
        end
        kick();
        wait_done(5000);
        repeat (10) @(negedge clk);
        chk("full_end_addr", bus.rom_addr, 8'hFF);
        chk("full_pulses", pulses, 256);
        chk("full_done_held", done, 1);

        // Reset during WAIT_DONE, then a clean re-run.
        begin
            int n = 0;
            for (int i = 0; i < 256; i++) rom[i] = ROM_END;
            rom[0] = 16'h5566;
            rom[1] = 16'h7788;
            exp_q.push_back(16'h5566);
            exp_q.push_back(16'h7788);
            busy_len = 30;
            kick();
            while (pulses == 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("rstmid_first_pulse", pulses, 1);
            repeat (5) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("rstmid_rom_addr", bus.rom_addr, 0);
            chk("rstmid_start", bus.sccb_start, 0);
            chk("rstmid_reg_val", {bus.sccb_reg, bus.sccb_val}, 0);
            chk("rstmid_done", done, 0);
            exp_q.delete();
            busy_len = 1;
            @(negedge clk) rst = 1'b0;
            run_vec(vecs[3]);
        end

`ifdef OV7670_CFG_TIMEOUT_EN
        begin
            int n = 0;
            for (int i = 0; i < 256; i++) rom[i] = ROM_END;
            rom[0] = 16'h1234;
            hold_low = 1'b1;
            kick();
            while (!done && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", n, 102);
            chk("timeout_err", err, 1);
            chk("timeout_no_pulse", pulses, 0);
            hold_low = 1'b0;
            run_vec(vecs[0]);
            chk("timeout_err_cleared", err, 0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
